// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, result widths and the
// result-reader state encoding.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam int RES_W  = 64;

    localparam logic [4:0] ADD_OPCODE = 5'b00001;
    localparam logic [4:0] MUL_OPCODE = 5'b01110;
    localparam logic [4:0] DIV_OPCODE = 5'b01111;

    localparam logic [1:0] IDLE_ENC    = 2'd0;
    localparam logic [1:0] SEND_LO_ENC = 2'd1;
    localparam logic [1:0] SEND_HI_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = IDLE_ENC,
        SEND_LO = SEND_LO_ENC,
        SEND_HI = SEND_HI_ENC
    } rr_state_t;

endpackage

// File: rtl/z_result_reader.sv
// Captures the 64-bit ALU result and streams it onto the 32-bit bus
// (LO then HI for MUL/DIV, LO only otherwise) with zero/neg flags.
// Ports: clk, clr (async active-low), c_in/opcode/c_valid/c_ready
// (ALU side), bus_data/bus_valid/bus_ready/bus_hi (bus side),
// zero/neg (flags of last capture), drop_err (sticky overrun).
module z_result_reader #(
    parameter logic [4:0] MUL_OPCODE = 5'b01110,
    parameter logic [4:0] DIV_OPCODE = 5'b01111
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [cpu_pkg::RES_W-1:0]  c_in,
    input  logic [4:0]                 opcode,
    input  logic                       c_valid,
    output logic                       c_ready,
    output logic [cpu_pkg::WORD_W-1:0] bus_data,
    output logic                       bus_valid,
    input  logic                       bus_ready,
    output logic                       bus_hi,
    output logic                       zero,
    output logic                       neg,
    output logic                       drop_err
);

    import cpu_pkg::*;

    rr_state_t         state_q, state_d;
    logic [RES_W-1:0]  z_q, z_d;
    logic [4:0]        op_q, op_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              drop_q, drop_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              hi_q, hi_d;

    logic              in_wide;
    logic              wide;

    assign in_wide = (opcode == MUL_OPCODE) || (opcode == DIV_OPCODE);
    assign wide    = (op_q == MUL_OPCODE) || (op_q == DIV_OPCODE);

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        op_d    = op_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        data_d  = data_q;
        valid_d = valid_q;
        hi_d    = hi_q;
        // Any strobe outside IDLE is an overrun, including the cycle
        // in which the last word is being accepted.
        drop_d  = drop_q | (c_valid && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (c_valid) begin
                    op_d    = opcode;
                    // Narrow results never carry the upper half.
                    z_d     = in_wide ? c_in
                                      : {{WORD_W{1'b0}}, c_in[WORD_W-1:0]};
                    zero_d  = in_wide ? (c_in == '0)
                                      : (c_in[WORD_W-1:0] == '0);
                    neg_d   = in_wide ? c_in[RES_W-1] : c_in[WORD_W-1];
                    data_d  = c_in[WORD_W-1:0];
                    valid_d = 1'b1;
                    hi_d    = 1'b0;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (bus_ready) begin
                    if (wide) begin
                        data_d  = z_q[RES_W-1:WORD_W];
                        hi_d    = 1'b1;
                        state_d = SEND_HI;
                    end else begin
                        data_d  = '0;
                        valid_d = 1'b0;
                        hi_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            SEND_HI: begin
                if (bus_ready) begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    hi_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                data_d  = '0;
                valid_d = 1'b0;
                hi_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            z_q     <= '0;
            op_q    <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            drop_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            op_q    <= op_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            hi_q    <= hi_d;
        end
    end

    assign c_ready   = (state_q == IDLE);
    assign bus_data  = data_q;
    assign bus_valid = valid_q;
    assign bus_hi    = hi_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign drop_err  = drop_q;

endmodule
